bus_master_port: RTL and testbench

- Master-side bus interface: one instance per bus master, feeding the arbiter's `breq` input and consuming its `bgrant` and `msplit` outputs.
- Accepts one parallel read/write command from the local master core and requests the bus.
- On grant, serialises address and write data onto the shared 1-bit bus, deserialises read data, and returns the result to the core.
- Holds its request through split transactions so the arbiter can resume it.

---
 rtl/bus_pkg.sv | 32 +++
 rtl/serial_shift_unit.sv | 56 +++++
 rtl/bus_master_port.sv | 279 +++++++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: state encoding, transfer modes and default widths.
// Used by the master port, the slave port and the arbiter.
// No logic and no ports; types, constants and a small helper only.
package bus_pkg;

  // Default widths shared by every agent on the serial bus. The upper
  // address bits carry the slave select.
  localparam int BUS_ADDR_WIDTH = 14;
  localparam int BUS_DATA_WIDTH = 8;

  // Transfer direction as carried on d_mode / mmode.
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Master port transaction states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    ACK,
    WDATA,
    RDATA,
    SPLIT,
    DONE
  } bus_state_e;

  // Elaboration-time maximum, used to size shared registers.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shift_unit.sv
// Load / shift register with bit counter and last-bit flag for serial links.
// Latency: load or shift takes effect on the next rising clk edge.
// No backpressure: the owner decides each cycle whether to load or shift.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   load_i, load_dat_i     parallel load; also clears the bit counter
//   shift_i, sin_i         right shift, sin_i enters at the MSB (shift-in),
//                          dat_o[0] is the bit being shifted out (shift-out)
//   last_idx_i             counter value that marks the final bit
//   dat_o                  register contents
//   last_o                 current bit is the final one of the burst
module serial_shift_unit #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             shift_i,
  input  logic             sin_i,
  input  logic [CW-1:0]    last_idx_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             last_o
);

  logic [WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (load_i) begin
      dat_d = load_dat_i;
      cnt_d = '0;
    end else if (shift_i) begin
      dat_d = {sin_i, dat_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign dat_o  = dat_q;
  assign last_o = (cnt_q == last_idx_i);

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: takes one parallel command, requests the bus,
// serialises addr/wdata, deserialises rdata. Latency after grant (write, no
// wait states): 1 + ADDR_WIDTH + 1 + DATA_WIDTH + 1 cycles. Backpressure:
// d_ready low from accept until back in IDLE; bus stalls follow mbgrant/sack.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   d_valid/d_ready           command handshake from the master core
//   d_mode/d_addr/d_wdata     command: 0=read 1=write, address, write data
//   d_rdata/d_done/d_err      completion: read data, done pulse, abort pulse
//   mbreq/mbgrant/msplit      arbiter request, grant and split indication
//   mwdata/mwvalid/mmode      serial addr/wdata out (LSB first), mode
//   sack                      slave address acknowledge
//   mrdata/mrvalid            serial read data in (LSB first)
//
// Build option: define ACK_TIMEOUT_EN to abort with d_err when sack (or the
// end of a split) does not arrive within ACK_TIMEOUT cycles.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic                  d_mode,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic                  mbreq,
  input  logic                  mbgrant,
  input  logic                  msplit,
  output logic                  mwdata,
  output logic                  mwvalid,
  output logic                  mmode,
  input  logic                  sack,
  input  logic                  mrdata,
  input  logic                  mrvalid
);

  // One TX register carries both the address and the write data, so it is
  // sized for the wider of the two.
  localparam int TX_W  = max_int(ADDR_WIDTH, DATA_WIDTH);
  localparam int TX_CW = $clog2(TX_W + 1);
  localparam int RX_CW = $clog2(DATA_WIDTH + 1);

  localparam logic [TX_CW-1:0] TX_ADDR_LAST = TX_CW'(ADDR_WIDTH - 1);
  localparam logic [TX_CW-1:0] TX_DATA_LAST = TX_CW'(DATA_WIDTH - 1);
  localparam logic [RX_CW-1:0] RX_LAST      = RX_CW'(DATA_WIDTH - 1);

  bus_state_e state_q, state_d;

  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cmd_acc;

  logic             tx_load, tx_shift, tx_last;
  logic [TX_W-1:0]  tx_load_dat, tx_dat;
  logic [TX_CW-1:0] tx_last_idx;

  logic                  rx_load, rx_shift, rx_last;
  logic [DATA_WIDTH-1:0] rx_dat;

`ifdef ACK_TIMEOUT_EN
  localparam int TO_W = max_int(4, $clog2(ACK_TIMEOUT + 1));
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            to_hit;
  logic            err_q, err_d;

  // Counts cycles spent waiting in ACK or SPLIT; any other state clears it.
  assign to_d   = (state_q == ACK || state_q == SPLIT) ? to_q + TO_W'(1) : '0;
  assign to_hit = (to_q == TO_LAST);
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = (ACK_TIMEOUT > 0);
`endif

  // Bit 0 of rx_dat is the reset filler that falls out on the final shift;
  // only bit 0 of the TX register ever reaches the bus.
  logic unused_shift_bits;
  assign unused_shift_bits = rx_dat[0] ^ (^tx_dat[TX_W-1:1]);

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    cmd_acc     = 1'b0;
    tx_load     = 1'b0;
    tx_load_dat = '0;
    tx_shift    = 1'b0;
    tx_last_idx = TX_ADDR_LAST;
    rx_load     = 1'b0;
    rx_shift    = 1'b0;
`ifdef ACK_TIMEOUT_EN
    err_d       = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (d_valid) begin
          cmd_acc = 1'b1;
          rx_load = 1'b1;  // clear the receive register and its counter
          state_d = REQ;
`ifdef ACK_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end

      REQ: begin
        // Every (re)start of the bus phase reloads the address, so a
        // transaction interrupted by grant loss always resends from bit 0.
        if (mbgrant) begin
          tx_load     = 1'b1;
          tx_load_dat = TX_W'(addr_q);
          state_d     = ADDR;
        end
      end

      ADDR: begin
        if (!mbgrant) begin
          state_d = REQ;
        end else begin
          tx_shift = 1'b1;
          if (tx_last) state_d = ACK;
        end
      end

      ACK: begin
        // sack wins over a coincident msplit; RDATA re-samples msplit.
        if (mbgrant && sack) begin
          if (mode_q == MODE_WRITE) begin
            tx_load     = 1'b1;
            tx_load_dat = TX_W'(wdata_q);
            state_d     = WDATA;
          end else begin
            state_d = RDATA;
          end
        end
`ifdef ACK_TIMEOUT_EN
        else if (to_hit) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
`endif
      end

      WDATA: begin
        tx_last_idx = TX_DATA_LAST;
        if (!mbgrant) begin
          state_d = REQ;
        end else begin
          tx_shift = 1'b1;
          if (tx_last) state_d = DONE;
        end
      end

      RDATA: begin
        if (msplit) begin
          state_d = SPLIT;
        end else if (mbgrant && mrvalid) begin
          rx_shift = 1'b1;
          if (rx_last) begin
            // Capture including the bit arriving this cycle.
            rdata_d = {mrdata, rx_dat[DATA_WIDTH-1:1]};
            state_d = DONE;
          end
        end
      end

      SPLIT: begin
        // Bit count is held in the RX unit; mrvalid is ignored here.
        if (!msplit && mbgrant) begin
          state_d = RDATA;
        end
`ifdef ACK_TIMEOUT_EN
        else if (to_hit) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (cmd_acc) begin
        mode_q  <= d_mode;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end
    end
  end

`ifdef ACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign d_err = (state_q == DONE) && err_q;
`else
  assign d_err = 1'b0;
`endif

  serial_shift_unit #(
    .WIDTH (TX_W),
    .CW    (TX_CW)
  ) u_tx (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (tx_load),
    .load_dat_i (tx_load_dat),
    .shift_i    (tx_shift),
    .sin_i      (1'b0),
    .last_idx_i (tx_last_idx),
    .dat_o      (tx_dat),
    .last_o     (tx_last)
  );

  serial_shift_unit #(
    .WIDTH (DATA_WIDTH),
    .CW    (RX_CW)
  ) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (rx_load),
    .load_dat_i ('0),
    .shift_i    (rx_shift),
    .sin_i      (mrdata),
    .last_idx_i (RX_LAST),
    .dat_o      (rx_dat),
    .last_o     (rx_last)
  );

  assign d_ready = (state_q == IDLE);
  assign d_done  = (state_q == DONE);
  assign d_rdata = rdata_q;
  assign mbreq   = (state_q != IDLE) && (state_q != DONE);

  // A bit only goes on the wire in a granted cycle; the cycle in which the
  // grant is lost is not counted and the whole phase restarts.
  assign mwvalid = mbgrant && (state_q == ADDR || state_q == WDATA);
  assign mwdata  = mwvalid && tx_dat[0];
  assign mmode   = mbgrant && (state_q != IDLE) && (state_q != REQ) && mode_q;

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int TO = 15;
`ifdef ACK_TIMEOUT_EN
  localparam int SPLIT_CYC = 10;
`else
  localparam int SPLIT_CYC = 20;
`endif

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } txn_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          d_valid, d_ready, d_mode;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_done, d_err;
  logic          mbreq, mbgrant, msplit;
  logic          mwdata, mwvalid, mmode;
  logic          sack, mrdata, mrvalid;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic cur_mode = 1'b0;
  logic [7:0] last_rdata = 8'h00;

  logic exp_bits[$];
  txn_t exp_txn[$];

  bus_master_port dut (
    .clk     (clk),
    .rstn    (rstn),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d_mode  (d_mode),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_err   (d_err),
    .mbreq   (mbreq),
    .mbgrant (mbgrant),
    .msplit  (msplit),
    .mwdata  (mwdata),
    .mwvalid (mwvalid),
    .mmode   (mmode),
    .sack    (sack),
    .mrdata  (mrdata),
    .mrvalid (mrvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitor: pops expected serial bits and completions.
  always @(negedge clk) begin : mon
    txn_t t;
    if (rstn === 1'b1 && mwvalid === 1'b1) begin
      if (exp_bits.size() == 0) fail_now("mwdata_unexpected");
      else chk("mwdata", 32'(mwdata), 32'(exp_bits.pop_front()));
      chk("mmode", 32'(mmode), 32'(cur_mode));
    end
    if (d_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("mbreq_in_done", 32'(mbreq), 32'(0));
      if (exp_txn.size() == 0) fail_now("done_unexpected");
      else begin
        t = exp_txn.pop_front();
        chk("d_rdata", 32'(d_rdata), 32'(t.rdata));
        chk("d_err", 32'(d_err), 32'(t.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_bits.push_back(v[i]);
  endtask

  task automatic push_txn(input logic [7:0] rd, input logic err);
    txn_t t;
    t.rdata = rd;
    t.err   = err;
    exp_txn.push_back(t);
  endtask

  task automatic issue(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] w);
    chk("d_ready_idle", 32'(d_ready), 32'(1));
    d_valid = 1'b1; d_mode = mode; d_addr = a; d_wdata = w; cur_mode = mode;
    tick();
    d_valid = 1'b0;
    chk("d_ready_busy", 32'(d_ready), 32'(0));
  endtask

  // Grant now, shift the whole address, ack in the cycle after the last bit.
  task automatic addr_phase(output int gcyc);
    mbgrant = 1'b1;
    gcyc = cyc;
    tick();
    repeat (AW) tick();
    sack = 1'b1;
    tick();
    sack = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      mrvalid = 1'b1;
      mrdata  = v[i];
      tick();
    end
    mrvalid = 1'b0;
    mrdata  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == start) fail_now({name, "_timeout"});
    mbgrant = 1'b0;
  endtask

  initial begin
    int g, a, low, d0;
    rstn = 1'b0; d_valid = 1'b0; d_mode = 1'b0; d_addr = '0; d_wdata = '0;
    mbgrant = 1'b0; msplit = 1'b0; sack = 1'b0; mrdata = 1'b0; mrvalid = 1'b0;
    #2;
    chk("rst_d_ready", 32'(d_ready), 32'(1));
    chk("rst_d_done", 32'(d_done), 32'(0));
    chk("rst_d_err", 32'(d_err), 32'(0));
    chk("rst_d_rdata", 32'(d_rdata), 32'(0));
    chk("rst_mbreq", 32'(mbreq), 32'(0));
    chk("rst_mwvalid", 32'(mwvalid), 32'(0));
    chk("rst_mmode", 32'(mmode), 32'(0));
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Write 0x0A5 <- 0x3C, grant two cycles after accept.
    push_bits(32'h0A5, AW); push_bits(32'h3C, DW); push_txn(last_rdata, 1'b0);
    issue(1'b1, 14'h00A5, 8'h3C);
    chk("mbreq_req", 32'(mbreq), 32'(1));
    tick();
    addr_phase(g);
    repeat (DW) tick();
    wait_done(5, "write");
    // done falls in the 25th cycle counting the grant cycle as the first
    chk("write_latency", 32'(done_cyc - g), 32'(AW + DW + 2));

    // Read 0x1001 -> 0xC9.
    push_bits(32'h1001, AW); push_txn(8'hC9, 1'b0);
    issue(1'b0, 14'h1001, 8'h00);
    addr_phase(g);
    send_rx(8'hC9, 0, 7);
    wait_done(5, "read");
    last_rdata = 8'hC9;

    // Split read 0x0777 -> 0x5A: 3 bits, split with grant gone, 5 bits.
    push_bits(32'h0777, AW); push_txn(8'h5A, 1'b0);
    issue(1'b0, 14'h0777, 8'h00);
    addr_phase(g);
    send_rx(8'h5A, 0, 2);
    msplit = 1'b1; mbgrant = 1'b0;
    tick();
    low = 0;
    for (int k = 0; k < SPLIT_CYC; k++) begin
      mrvalid = 1'b1; mrdata = 1'b1;  // must be ignored
      if (mbreq !== 1'b1) low++;
      tick();
    end
    mrvalid = 1'b0; mrdata = 1'b0; msplit = 1'b0; mbgrant = 1'b1;
    if (mbreq !== 1'b1) low++;
    tick();
    chk("mbreq_held_in_split", 32'(low), 32'(0));
    send_rx(8'h5A, 3, 7);
    wait_done(5, "split_read");
    last_rdata = 8'h5A;

    // Write 0x3A5C <- 0x81, grant lost at address bit 6.
    push_bits(32'h3A5C, 6); push_bits(32'h3A5C, AW); push_bits(32'h81, DW);
    push_txn(last_rdata, 1'b0);
    issue(1'b1, 14'h3A5C, 8'h81);
    mbgrant = 1'b1;
    tick();
    repeat (6) tick();
    mbgrant = 1'b0;
    tick();
    chk("mbreq_after_grant_loss", 32'(mbreq), 32'(1));
    tick();
    addr_phase(g);
    repeat (DW) tick();
    wait_done(5, "grant_drop_write");

`ifdef ACK_TIMEOUT_EN
    // No sack: abort after ACK_TIMEOUT cycles in ACK.
    push_bits(32'h0100, AW); push_txn(8'h00, 1'b1);
    issue(1'b0, 14'h0100, 8'h00);
    mbgrant = 1'b1;
    tick();
    repeat (AW) tick();
    a = cyc;
    wait_done(40, "ack_timeout");
    chk("timeout_latency", 32'(done_cyc - a), 32'(TO));
    chk("ready_after_timeout", 32'(d_ready), 32'(1));
    last_rdata = 8'h00;
`else
    // sack 25 cycles late: port keeps waiting, no error.
    push_bits(32'h0C33, AW); push_txn(8'h96, 1'b0);
    issue(1'b0, 14'h0C33, 8'h00);
    mbgrant = 1'b1;
    tick();
    repeat (AW + 25) tick();
    a = cyc;
    chk("late_ack_still_waiting", 32'(mbreq), 32'(1));
    sack = 1'b1;
    tick();
    sack = 1'b0;
    send_rx(8'h96, 0, 7);
    wait_done(5, "late_ack_read");
    chk("late_ack_latency", 32'(done_cyc - a), 32'(DW + 1));
    last_rdata = 8'h96;
`endif

    // Reset in the middle of WDATA (after 3 data bits).
    push_bits(32'h2222, AW); push_bits(32'hE7, 3);
    issue(1'b1, 14'h2222, 8'hE7);
    addr_phase(g);
    repeat (3) tick();
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    chk("arst_d_ready", 32'(d_ready), 32'(1));
    chk("arst_mbreq", 32'(mbreq), 32'(0));
    chk("arst_mwvalid", 32'(mwvalid), 32'(0));
    chk("arst_mwdata", 32'(mwdata), 32'(0));
    chk("arst_mmode", 32'(mmode), 32'(0));
    chk("arst_d_done", 32'(d_done), 32'(0));
    chk("arst_d_rdata", 32'(d_rdata), 32'(0));
    tick(); tick();
    mbgrant = 1'b0;
    rstn = 1'b1;
    tick();
    chk("ready_after_arst", 32'(d_ready), 32'(1));
    repeat (5) tick();
    chk("no_done_after_arst", 32'(done_cnt), 32'(d0));

    chk("bits_left_over", 32'(exp_bits.size()), 32'(0));
    chk("txns_left_over", 32'(exp_txn.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
